// File: rtl/barrel_shift_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
// Shift levels are split into register groups here so the top and any checker agree on the split.
package barrel_shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } sh_mode_t;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned SH_W_DEF   = $clog2(DATA_W_DEF);

  // Payload at the default widths; the top rebuilds the same layout at its own widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    sh_mode_t              mode;
    logic                  sign;
    logic                  carry;
    logic [SH_W_DEF-1:0]   amt;
    logic [TAG_W_DEF-1:0]  tag;
  } stage_payload_t;

  function automatic int unsigned levels_per_group(input int unsigned sh_w,
                                                   input int unsigned stages);
    return (sh_w + stages - 1) / stages;
  endfunction

  function automatic int unsigned first_level(input int unsigned k,
                                              input int unsigned sh_w,
                                              input int unsigned stages);
    return k * levels_per_group(sh_w, stages);
  endfunction

  // Full groups first; whatever is left lands in the later groups, which may be empty.
  function automatic int unsigned levels_in_stage(input int unsigned k,
                                                  input int unsigned sh_w,
                                                  input int unsigned stages);
    int unsigned first;
    int unsigned per;
    per   = levels_per_group(sh_w, stages);
    first = k * per;
    if (first >= sh_w) begin
      return 0;
    end
    return ((sh_w - first) < per) ? (sh_w - first) : per;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: right shift by SHIFT when enabled.
// Fill is zero, the carried sign bit, or the wrapped low bits for rotate.
module shift_level
  import barrel_shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SHIFT  = 1
) (
  input  logic [DATA_W-1:0] i_data,
  input  sh_mode_t          i_mode,
  input  logic              i_sign,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      unique case (i_mode)
        MODE_ROR: o_data = {i_data[SHIFT-1:0], i_data[DATA_W-1:SHIFT]};
        MODE_ASR: o_data = {{SHIFT{i_sign}}, i_data[DATA_W-1:SHIFT]};
        // Left shifts arrive bit-reversed, so they also take a zero fill here.
        MODE_LSL,
        MODE_LSR: o_data = {{SHIFT{1'b0}}, i_data[DATA_W-1:SHIFT]};
        default:  o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR) with valid/ready flow control and a carried tag.
// SH_W right-shift levels are spread over PIPE_STAGES registered groups; bubbles collapse.
module pipelined_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4,
  localparam int unsigned SH_W       = $clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_sh_mode,
  input  logic [SH_W-1:0]   i_sh_amt,
  input  logic [DATA_W-1:0] i_d_in,
  input  logic [TAG_W-1:0]  i_tag_in,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_carry_out,
  output logic [TAG_W-1:0]  o_tag_out
);

  localparam int unsigned LAST   = PIPE_STAGES - 1;
  localparam int unsigned LVL_PG = levels_per_group(SH_W, PIPE_STAGES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    sh_mode_t          mode;
    logic              sign;
    logic              carry;
    logic [SH_W-1:0]   amt;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

  logic [PIPE_STAGES-1:0] r_valid;
  stage_t                 r_stage     [PIPE_STAGES];
  stage_t                 w_stage_in  [PIPE_STAGES];
  stage_t                 w_stage_nxt [PIPE_STAGES];
  logic [DATA_W-1:0]      w_shifted   [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] w_en;
  logic [PIPE_STAGES:0]   w_vchain;
  stage_t                 w_in_beat;
  sh_mode_t               w_in_mode;
  logic [SH_W-1:0]        w_carry_idx;

  // Carry is resolved from the raw operand at accept and then rides along with the beat.
  always_comb begin
    w_in_mode   = sh_mode_t'(i_sh_mode);
    w_carry_idx = (w_in_mode == MODE_LSL) ? SH_W'(-i_sh_amt) : SH_W'(i_sh_amt - 1'b1);
    w_in_beat.data  = (w_in_mode == MODE_LSL) ? bit_rev(i_d_in) : i_d_in;
    w_in_beat.mode  = w_in_mode;
    w_in_beat.sign  = i_d_in[DATA_W-1];
    w_in_beat.carry = (i_sh_amt != '0) && i_d_in[w_carry_idx];
    w_in_beat.amt   = i_sh_amt;
    w_in_beat.tag   = i_tag_in;
  end

  always_comb begin
    w_stage_in[0] = w_in_beat;
    for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
      w_stage_in[k] = r_stage[k-1];
    end
  end

  for (genvar l = 0; l < SH_W; l++) begin : g_level
    localparam int unsigned STG = l / LVL_PG;
    logic [DATA_W-1:0] w_in;
    logic [DATA_W-1:0] w_out;

    if (l % LVL_PG == 0) begin : g_head
      assign w_in = w_stage_in[STG].data;
    end else begin : g_chain
      assign w_in = g_level[l-1].w_out;
    end

    shift_level #(
      .DATA_W (DATA_W),
      .SHIFT  (2 ** l)
    ) u_shift_level (
      .i_data (w_in),
      .i_mode (w_stage_in[STG].mode),
      .i_sign (w_stage_in[STG].sign),
      .i_en   (w_stage_in[STG].amt[l]),
      .o_data (w_out)
    );
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    localparam int unsigned FIRST = first_level(k, SH_W, PIPE_STAGES);
    localparam int unsigned NLV   = levels_in_stage(k, SH_W, PIPE_STAGES);

    if (NLV == 0) begin : g_empty
      assign w_shifted[k] = w_stage_in[k].data;
    end else begin : g_levels
      assign w_shifted[k] = g_level[FIRST+NLV-1].w_out;
    end
  end

  // The last group undoes the input reversal so the output register holds the true result.
  always_comb begin
    for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
      w_stage_nxt[k]      = w_stage_in[k];
      w_stage_nxt[k].data = w_shifted[k];
    end
    if (w_stage_in[LAST].mode == MODE_LSL) begin
      w_stage_nxt[LAST].data = bit_rev(w_shifted[LAST]);
    end
  end

  // A stage may load when it is empty or everything downstream of it can advance.
  always_comb begin
    logic w_acc;
    w_acc      = i_out_ready || !r_valid[LAST];
    w_en       = '0;
    w_en[LAST] = w_acc;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      w_acc   = w_acc || !r_valid[k];
      w_en[k] = w_acc;
    end
  end

  assign w_vchain = {r_valid, i_in_valid};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
        if (w_en[k]) begin
          r_valid[k] <= w_vchain[k];
          if (w_vchain[k]) begin
            r_stage[k] <= w_stage_nxt[k];
          end
        end
      end
    end
  end

  assign o_in_ready  = w_en[0];
  assign o_out_valid = r_valid[LAST];
  assign o_d_out     = r_stage[LAST].data;
  assign o_carry_out = r_stage[LAST].carry;
  assign o_tag_out   = r_stage[LAST].tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: directed corner beats, backpressure, async reset and a random scoreboard
// run against an arithmetic reference model of the four shift modes.
module tb_pipelined_barrel_shifter;

  parameter int unsigned PIPE = 2;

  typedef struct packed {
    logic [1:0]  mode;
    logic [4:0]  amt;
    logic [31:0] d;
    logic [3:0]  tag;
    logic [31:0] exp_d;
    logic        exp_c;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sh_mode;
  logic [4:0]  sh_amt;
  logic [31:0] d_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d_out;
  logic        carry_out;
  logic [3:0]  tag_out;

  pipelined_barrel_shifter #(
    .DATA_W      (32),
    .PIPE_STAGES (PIPE),
    .TAG_W       (4)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_sh_mode   (sh_mode),
    .i_sh_amt    (sh_amt),
    .i_d_in      (d_in),
    .i_tag_in    (tag_in),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_d_out     (d_out),
    .o_carry_out (carry_out),
    .o_tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  logic [36:0] exp_q[$];
  logic        prev_stall;
  logic [36:0] prev_out;
  logic        last_emit;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic per mode; carry is the last bit pushed off the end.
  function automatic logic [32:0] ref_shift(input logic [1:0] m, input int a,
                                            input logic [31:0] d);
    longint unsigned dd;
    longint unsigned r;
    logic            c;
    dd = {32'h0, d};
    r  = dd;
    c  = 1'b0;
    case (m)
      2'd0: begin
        r = (dd << a) & 64'hFFFF_FFFF;
        if (a != 0) c = ((dd >> (32 - a)) & 64'd1) != 0;
      end
      2'd1: begin
        r = dd >> a;
        if (a != 0) c = ((dd >> (a - 1)) & 64'd1) != 0;
      end
      2'd2: begin
        if (d[31]) dd = dd | 64'hFFFF_FFFF_0000_0000;
        r = (dd >> a) & 64'hFFFF_FFFF;
        if (a != 0) c = ((dd >> (a - 1)) & 64'd1) != 0;
      end
      default: begin
        r = ((dd >> a) | (dd << (32 - a))) & 64'hFFFF_FFFF;
        if (a != 0) c = ((r >> 31) & 64'd1) != 0;
      end
    endcase
    return {c, r[31:0]};
  endfunction

  function automatic beat_t mk(input logic [1:0] m, input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] t);
    beat_t       b;
    logic [32:0] r;
    r       = ref_shift(m, int'(a), d);
    b.mode  = m;
    b.amt   = a;
    b.d     = d;
    b.tag   = t;
    b.exp_d = r[31:0];
    b.exp_c = r[32];
    return b;
  endfunction

  function automatic beat_t mkx(input logic [1:0] m, input logic [4:0] a, input logic [31:0] d,
                                input logic [3:0] t, input logic [31:0] ed, input logic ec);
    beat_t b;
    b.mode  = m;
    b.amt   = a;
    b.d     = d;
    b.tag   = t;
    b.exp_d = ed;
    b.exp_c = ec;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(2'($urandom_range(3)), 5'($urandom_range(31)), $urandom, 4'($urandom_range(15)));
  endfunction

  // One cycle: drive after the falling edge, observe the handshakes just before the rising edge.
  task automatic step(input logic vld, input beat_t b, input logic ordy, output logic acc);
    logic [36:0] e;
    @(negedge clk);
    in_valid  = vld;
    sh_mode   = b.mode;
    sh_amt    = b.amt;
    d_in      = b.d;
    tag_in    = b.tag;
    out_ready = ordy;
    #2;
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_data", 64'({tag_out, carry_out, d_out}), 64'(prev_out));
    end
    last_emit = out_valid && out_ready;
    if (last_emit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("result_tag_carry_data", 64'({tag_out, carry_out, d_out}), 64'(e));
      end
    end
    acc = vld && in_ready;
    if (acc) exp_q.push_back({b.tag, b.exp_c, b.exp_d});
    prev_stall = out_valid && !out_ready;
    prev_out   = {tag_out, carry_out, d_out};
  endtask

  task automatic send(input beat_t b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      step(1'b1, b, 1'b1, acc);
      n++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && (exp_q.size() != 0 || out_valid); i++) begin
      step(1'b0, beat_t'(0), 1'b1, acc);
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    beat_t bp[8];
    logic  acc;
    int    idx;
    int    lat;
    int    accepted;
    int    cyc;

    n_checks   = 0;
    n_errors   = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    last_emit  = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sh_mode    = '0;
    sh_amt     = '0;
    d_in       = '0;
    tag_in     = '0;
    out_ready  = 1'b0;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_d_out", 64'(d_out), 64'(0));
    check("reset_carry", 64'(carry_out), 64'(0));
    check("reset_tag", 64'(tag_out), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // ASR of the sign bit yields a ones prefix AMT+1 wide; no set bit is ever shifted out.
    for (int a = 0; a < 32; a++) begin
      send(mkx(2'd2, 5'(a), 32'h8000_0000, 4'(a), 32'hFFFF_FFFF << (31 - a), 1'b0));
    end
    drain(100);

    send(mkx(2'd1, 5'd30, 32'h4000_0000, 4'd1, 32'h0000_0001, 1'b0));
    send(mkx(2'd1, 5'd31, 32'h4000_0000, 4'd2, 32'h0000_0000, 1'b1));
    send(mkx(2'd0, 5'd31, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b0));
    send(mkx(2'd0, 5'd1, 32'h8000_0001, 4'd4, 32'h0000_0002, 1'b1));
    send(mkx(2'd3, 5'd1, 32'h0000_0001, 4'd5, 32'h8000_0000, 1'b1));
    send(mkx(2'd3, 5'd8, 32'h1234_5678, 4'd6, 32'h7812_3456, 1'b0));
    for (int m = 0; m < 4; m++) begin
      send(mkx(2'(m), 5'd0, 32'hF00D_BEEF, 4'(8 + m), 32'hF00D_BEEF, 1'b0));
    end
    drain(100);

    // Backpressure: downstream stalled for six cycles while eight beats are offered.
    for (int i = 0; i < 8; i++) bp[i] = mk(2'($urandom_range(3)), 5'($urandom_range(31)),
                                           $urandom, 4'(i));
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, bp[idx], 1'b0, acc);
      if (acc) idx++;
    end
    @(posedge clk);
    #1;
    check("bp_beats_stored", 64'(idx), 64'(PIPE));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      step(1'b1, bp[idx], 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    check("bp_all_sent", 64'(idx), 64'(8));
    drain(100);

    // Asynchronous reset with the pipe full, then unloaded latency of the first new beat.
    for (int c = 0; c < int'(PIPE) + 2; c++) step(1'b1, rnd_beat(), 1'b0, acc);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_d_out", 64'(d_out), 64'(0));
    check("async_rst_tag", 64'(tag_out), 64'(0));
    exp_q.delete();
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, mk(2'd1, 5'd4, 32'hABCD_0123, 4'd9), 1'b1, acc);
    check("post_rst_accept", 64'(acc), 64'(1));
    lat = 0;
    last_emit = 1'b0;
    while (!last_emit && lat < 20) begin
      step(1'b0, beat_t'(0), 1'b1, acc);
      lat++;
    end
    check("post_rst_latency", 64'(lat), 64'(PIPE));
    drain(50);

    accepted = 0;
    cyc      = 0;
    b        = rnd_beat();
    while (accepted < 10000 && cyc < 60000) begin
      step($urandom_range(9) < 7, b, $urandom_range(9) < 7, acc);
      cyc++;
      if (acc) begin
        accepted++;
        b = rnd_beat();
      end
    end
    check("rand_beats_accepted", 64'(accepted), 64'(10000));
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
